uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of byte entries in the transmit FIFO (power of 2, 2..16).
REQ-002 Parameter LVL_W, default 3, width of fifo_level; SHALL equal log2(DEPTH)+1.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 resetb  input  1  reset, asynchronous assert, active-low.
REQ-005 div  input  16  bit period in clock cycles; sampled once per frame.
REQ-006 tx_data  input  8  byte to enqueue.
REQ-007 tx_valid  input  1  producer offers tx_data this cycle.
REQ-008 tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 ser_tx  output  1  serial line, idle high; drives mprj_io[6] (UART TX pad).
REQ-010 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-011 fifo_level  output  LVL_W  number of bytes currently queued, excluding the byte being shifted.

Function
REQ-012 Push occurs on a clock edge where tx_valid && tx_ready; a push appends tx_data at the tail.
REQ-013 tx_ready = (fifo_level < DEPTH), derived from registered state only; it SHALL NOT depend on tx_valid or on a same-cycle pop.
REQ-014 When full, the FIFO holds tx_valid with no data loss; a pop in the same cycle does not allow a push until the next cycle.
REQ-015 Frame format 8N1: one start bit (0), eight data bits LSB first, one stop bit (1); no parity.
REQ-016 FSM states: IDLE, START, DATA, STOP; encoding is free.
REQ-017 IDLE -> START on the edge where the FIFO is non-empty: pop head into the shift register, latch eff_div = max(div,1), clear the bit counter, and drive ser_tx=0 from the next cycle.
REQ-018 Each of START, DATA (per bit), and STOP lasts exactly eff_div clock cycles, counted by a 16-bit down/up counter.
REQ-019 START -> DATA after eff_div cycles; DATA shifts out 8 bits, then -> STOP; STOP drives ser_tx=1 for eff_div cycles.
REQ-020 STOP exit: if the FIFO is non-empty -> START directly (pop in the same cycle, back-to-back frames with no idle gap); else -> IDLE.
REQ-021 A frame occupies exactly 10*eff_div cycles; div changes mid-frame SHALL NOT affect the current frame.
REQ-022 A push and a pop on the same edge SHALL leave fifo_level unchanged and preserve order.
REQ-023 Read and write pointers wrap modulo DEPTH; fifo_level is the occupancy count, not a pointer difference.
REQ-024 ser_tx SHALL be registered (glitch-free); ser_tx=1 in IDLE.
REQ-025 busy = (state != IDLE) || (fifo_level != 0).

Reset
REQ-026 While resetb=0: state=IDLE, ser_tx=1, busy=0, fifo_level=0, tx_ready=0; pointers and counters are cleared.
REQ-027 The first clock edge after resetb rises SHALL set tx_ready=1 (deassertion is synchronized through one flop).
REQ-028 Reset asserted mid-frame SHALL force ser_tx=1 immediately (asynchronously) and discard the partial frame and all queued bytes.

Verification
REQ-029 div=4, push 0xA5 once -> ser_tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), high 4 cycles; 40 cycles total; busy then falls.
REQ-030 div=0 and div=1, push 0x00 -> both give 1-cycle bits, 10-cycle frame.
REQ-031 div=3, push 6 bytes 0x01..0x06 with tx_valid held -> tx_ready drops after the 5th accepted (1 shifting + 4 queued); all 6 arrive in order, with no gap between stop and next start.
REQ-032 Full FIFO with a pop on the same edge as tx_valid -> no push that cycle, push on the next cycle; no byte is lost or duplicated.
REQ-033 div=8, change div to 2 during DATA bit 3 -> the current frame stays at 8 cycles/bit; the next frame uses 2.
REQ-034 Assert resetb=0 mid-DATA with 3 bytes queued -> ser_tx=1 within the same cycle; after release, fifo_level=0, busy=0, and no residual frame appears.
REQ-035 Bench-level: the serial stream (div=1042 at 25 ns, 38400 baud) is received by tbuart on mprj_io[6], which prints the expected string.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte-wide transmit FIFO feeding an 8N1 UART serializer.
// The bit period is latched once per frame from div (0 treated as 1).
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int LVL_W = 3
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic [15:0]      div,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             ser_tx,
   output logic             busy,
   output logic [LVL_W-1:0] fifo_level
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_nxt;
   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [LVL_W-1:0] level;
   logic             rdy_en;
   logic [15:0]      eff_div, cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             push, pop, bit_done;

   function automatic logic [15:0] clamp_div(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

   // rdy_en holds tx_ready low until the first edge after reset release
   assign tx_ready   = rdy_en && (level < FULL_LVL);
   assign push       = tx_valid && tx_ready;
   assign bit_done   = (cnt == eff_div - 16'd1);
   assign fifo_level = level;
   assign busy       = (state != IDLE) || (level != '0);

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (level != '0) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: if (bit_done) state_nxt = DATA;
         DATA:  if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
         STOP: begin
            if (bit_done) begin
               if (level != '0) begin
                  pop       = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         rdy_en  <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         eff_div <= 16'd1;
         cnt     <= 16'd0;
         bit_idx <= 3'd0;
         ser_tx  <= 1'b1;
      end else begin
         rdy_en <= 1'b1;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         // A pop always begins a new frame with its start bit
         if (pop) begin
            eff_div <= clamp_div(div);
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            ser_tx  <= 1'b0;
         end else if (state != IDLE) begin
            if (bit_done) begin
               cnt <= 16'd0;
               case (state)
                  START: begin
                     ser_tx  <= shreg[0];
                     bit_idx <= 3'd0;
                  end
                  DATA: begin
                     if (bit_idx == 3'd7) begin
                        ser_tx <= 1'b1;
                     end else begin
                        ser_tx  <= shreg[1];
                        bit_idx <= bit_idx + 3'd1;
                     end
                  end
                  default: ser_tx <= 1'b1;
               endcase
            end else begin
               cnt <= cnt + 16'd1;
            end
         end
      end
   end

   // Storage and shift register carry data only and need no reset
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= tx_data;
      if (pop) shreg <= mem[rd_ptr];
      else if (state == DATA && bit_done) shreg <= {1'b0, shreg[7:1]};
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line monitor decodes every frame
// against a queue of expected bytes and bit widths built by the stimulus.
module tb_uart_tx_fifo;
   localparam int DEPTH = 4;
   localparam int LVL_W = 3;

   logic             clock = 1'b0;
   logic             resetb = 1'b0;
   logic [15:0]      div = 16'd4;
   logic [7:0]       tx_data = 8'h00;
   logic             tx_valid = 1'b0;
   logic             tx_ready, ser_tx, busy;
   logic [LVL_W-1:0] fifo_level;

   uart_tx_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
      .clock(clock), .resetb(resetb), .div(div), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .ser_tx(ser_tx),
      .busy(busy), .fifo_level(fifo_level)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {logic [7:0] b; int w;} frame_t;
   frame_t exp_q[$];
   int     starts[$];
   bit     mon_en = 1'b1;
   bit     m_active = 1'b0;
   int     frames_done = 0;

   // Line monitor: each frame must be 0, 8 data bits LSB first, 1, each w cycles
   initial begin
      frame_t     cur;
      int         k, idx, bad_k;
      logic       expb, bad_line, bad_exp;
      logic [7:0] bb;
      bit         ok;
      k = 0; bad_k = 0; ok = 1'b1; bad_line = 1'b0; bad_exp = 1'b0;
      cur.b = 8'h00; cur.w = 1;
      forever begin
         @(negedge clock);
         if (!mon_en || resetb !== 1'b1) begin
            m_active = 1'b0;
         end else begin
            if (!m_active && ser_tx === 1'b0) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_frame at cycle %0d: line=%b, required idle 1", cyc, ser_tx);
               end else begin
                  cur = exp_q.pop_front();
                  k = 0; ok = 1'b1; m_active = 1'b1;
                  starts.push_back(cyc);
               end
            end
            if (m_active) begin
               idx = k / cur.w;
               bb = cur.b;
               if (idx == 0)      expb = 1'b0;
               else if (idx == 9) expb = 1'b1;
               else               expb = bb[idx-1];
               if (ser_tx !== expb && ok) begin
                  ok = 1'b0; bad_k = k; bad_line = ser_tx; bad_exp = expb;
               end
               k++;
               if (k == 10 * cur.w) begin
                  if (!ok) begin
                     errors++;
                     $display("FAIL frame_%02h: sample %0d line=%b, required %b (%0d cycles/bit)",
                              cur.b, bad_k, bad_line, bad_exp, cur.w);
                  end
                  frames_done++;
                  m_active = 1'b0;
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Offer one byte; holds tx_valid across edges until tx_ready allows the push
   task automatic send(input logic [7:0] b, input int w, output int stall, output int acc_cyc);
      frame_t f;
      @(negedge clock);
      tx_data = b; tx_valid = 1'b1; stall = 0; acc_cyc = 0;
      while (tx_ready !== 1'b1 && stall < 2000) begin
         @(negedge clock);
         stall++;
      end
      checks++;
      if (stall >= 2000) begin
         errors++;
         $display("FAIL send_%02h: tx_ready=%b after %0d cycles, required 1", b, tx_ready, stall);
         tx_valid = 1'b0;
      end else begin
         @(posedge clock);
         f.b = b; f.w = w;
         exp_q.push_back(f);
         #1;
         acc_cyc = cyc;
         tx_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input int limit, output int idle_cyc);
      int n;
      n = 0;
      @(negedge clock);
      while ((busy !== 1'b0 || exp_q.size() != 0 || m_active) && n < limit) begin
         @(negedge clock);
         n++;
      end
      idle_cyc = cyc;
      checks++;
      if (n >= limit) begin
         errors++;
         $display("FAIL idle_timeout: busy=%b pending=%0d, required idle within %0d cycles",
                  busy, exp_q.size(), limit);
      end
   endtask

   task automatic wait_start(input int base, output int s);
      int n;
      n = 0;
      while (starts.size() <= base && n < 500) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (starts.size() <= base) begin
         errors++;
         $display("FAIL start_timeout: frames started=%0d, required >%0d", starts.size(), base);
         s = cyc;
      end else begin
         s = starts[base];
      end
   endtask

   task automatic test_reset();
      #12;
      checks += 4;
      if (ser_tx !== 1'b1)     begin errors++; $display("FAIL rst_ser_tx: got %b, required 1", ser_tx); end
      if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
      if (fifo_level !== '0)   begin errors++; $display("FAIL rst_level: got %0d, required 0", fifo_level); end
      if (tx_ready !== 1'b0)   begin errors++; $display("FAIL rst_ready: got %b, required 0", tx_ready); end
      @(negedge clock);
      resetb = 1'b1;
      #1;
      checks++;
      if (tx_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b, required 0", tx_ready); end
      @(posedge clock);
      #1;
      checks++;
      if (tx_ready !== 1'b1) begin errors++; $display("FAIL ready_first_edge: got %b, required 1", tx_ready); end
   endtask

   task automatic test_single();
      int st, ac, ic;
      div = 16'd4;
      send(8'hA5, 4, st, ac);
      wait_idle(300, ic);
      checks++;
      if (starts.size() == 0 || ic - starts[$] != 40) begin
         errors++;
         $display("FAIL single_span: busy fell %0d cycles after start, required 40",
                  starts.size() == 0 ? -1 : ic - starts[$]);
      end
   endtask

   task automatic test_min_div();
      int st, ac, ic;
      for (int d = 0; d < 2; d++) begin
         div = 16'(d);
         send(8'h00, 1, st, ac);
         wait_idle(100, ic);
         checks++;
         if (starts.size() == 0 || ic - starts[$] != 10) begin
            errors++;
            $display("FAIL min_div%0d_span: got %0d cycles, required 10", d,
                     starts.size() == 0 ? -1 : ic - starts[$]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int st[6], ac[6];
      int base, done0, ic, bad;
      logic [LVL_W-1:0] lvl5;
      logic rdy5;
      div = 16'd3;
      base = starts.size();
      done0 = frames_done;
      lvl5 = '0; rdy5 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         send(8'(i + 1), 3, st[i], ac[i]);
         if (i == 4) begin lvl5 = fifo_level; rdy5 = tx_ready; end
      end
      checks += 4;
      if (st[1] + st[2] + st[3] + st[4] != 0) begin
         errors++;
         $display("FAIL fill_stalls: bytes 2..5 stalled %0d cycles, required 0", st[1] + st[2] + st[3] + st[4]);
      end
      if (lvl5 !== 3'd4 || rdy5 !== 1'b0) begin
         errors++;
         $display("FAIL full_after5: level=%0d ready=%b, required level=4 ready=0", lvl5, rdy5);
      end
      if (st[5] == 0) begin errors++; $display("FAIL sixth_stall: got 0 stall cycles, required >0"); end
      if (starts.size() < base + 2 || ac[5] - starts[base+1] != 1) begin
         errors++;
         $display("FAIL push_after_pop: accepted %0d cycles after frame 2 start, required 1",
                  starts.size() < base + 2 ? -1 : ac[5] - starts[base+1]);
      end
      wait_idle(600, ic);
      bad = 0;
      for (int i = base; i + 1 < starts.size(); i++) if (starts[i+1] - starts[i] != 30) bad++;
      checks += 2;
      if (bad != 0 || starts.size() != base + 6) begin
         errors++;
         $display("FAIL b2b_gaps: %0d frames, %0d spacing errors, required 6 frames 30 apart",
                  starts.size() - base, bad);
      end
      if (frames_done - done0 != 6) begin
         errors++;
         $display("FAIL b2b_count: got %0d frames, required 6", frames_done - done0);
      end
   endtask

   task automatic test_div_change();
      int st, ac, base, s, n, ic;
      div = 16'd8;
      base = starts.size();
      send(8'h3C, 8, st, ac);
      send(8'hC3, 2, st, ac);
      wait_start(base, s);
      n = 0;
      while (cyc < s + 34 && n < 200) begin @(negedge clock); n++; end
      div = 16'd2;
      wait_idle(400, ic);
      checks += 2;
      if (starts.size() < base + 2 || starts[base+1] - starts[base] != 80) begin
         errors++;
         $display("FAIL divchg_frame1: spacing %0d, required 80",
                  starts.size() < base + 2 ? -1 : starts[base+1] - starts[base]);
      end
      if (starts.size() < base + 2 || ic - starts[base+1] != 20) begin
         errors++;
         $display("FAIL divchg_frame2: span %0d, required 20",
                  starts.size() < base + 2 ? -1 : ic - starts[base+1]);
      end
   endtask

   task automatic test_random();
      int st, ac, ic, d, w, n, done0;
      for (int r = 0; r < 5; r++) begin
         d = $urandom_range(0, 5);
         w = (d == 0) ? 1 : d;
         div = 16'(d);
         n = $urandom_range(1, 6);
         done0 = frames_done;
         for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, 3) * w);
            send(8'($urandom), w, st, ac);
         end
         wait_idle(1000, ic);
         checks++;
         if (frames_done - done0 != n) begin
            errors++;
            $display("FAIL random_round%0d: got %0d frames, required %0d", r, frames_done - done0, n);
         end
      end
   endtask

   task automatic test_reset_mid();
      int st, ac, base, s, n, lows, nstart;
      div = 16'd4;
      base = starts.size();
      for (int i = 0; i < 4; i++) send(8'h00, 4, st, ac);
      wait_start(base, s);
      n = 0;
      while (cyc < s + 14 && n < 200) begin @(negedge clock); n++; end
      mon_en = 1'b0;
      #2;
      resetb = 1'b0;
      #1;
      checks += 3;
      if (ser_tx !== 1'b1)   begin errors++; $display("FAIL midrst_ser_tx: got %b, required 1", ser_tx); end
      if (fifo_level !== '0) begin errors++; $display("FAIL midrst_level: got %0d, required 0", fifo_level); end
      if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy); end
      exp_q.delete();
      tick(2);
      resetb = 1'b1;
      tick(3);
      checks += 3;
      if (fifo_level !== '0) begin errors++; $display("FAIL postrst_level: got %0d, required 0", fifo_level); end
      if (busy !== 1'b0)     begin errors++; $display("FAIL postrst_busy: got %b, required 0", busy); end
      if (tx_ready !== 1'b1) begin errors++; $display("FAIL postrst_ready: got %b, required 1", tx_ready); end
      mon_en = 1'b1;
      nstart = starts.size();
      lows = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (ser_tx !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0 || starts.size() != nstart) begin
         errors++;
         $display("FAIL residual_frame: %0d low samples, required 0", lows);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_min_div();
      test_back_to_back();
      test_div_change();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
